// File: rtl/matrix_loader_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix loader and its stream interface:
//   ELEM_W / DIM / MAT_W   element width, matrix dimension, assembled width
//   NUM_ELEM / IDX_W       element count and width of an element index
//   MEM_LATCH / MEM_LOAD   encodings of the matrix memory's memory_state input
//   loader_state_t         loader FSM states
//   map_pos()              stream index -> storage position
// Optional build macro: MATRIX_LOADER_TRANSPOSE_EN selects transposed storage
// in map_pos(); without it storage is row-major (identity mapping).
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int ELEM_W   = 16;
  localparam int DIM      = 4;
  localparam int MAT_W    = ELEM_W * DIM * DIM;
  localparam int NUM_ELEM = DIM * DIM;
  localparam int IDX_W    = $clog2(NUM_ELEM);

  localparam logic MEM_LATCH = 1'b0;
  localparam logic MEM_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } loader_state_t;

  // Storage position of row-major stream element idx.
  function automatic logic [IDX_W-1:0] map_pos(input logic [IDX_W-1:0] idx);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    // Row r, column c of the stream lands at row c, column r of storage.
    map_pos = IDX_W'((int'(idx) % DIM) * DIM + (int'(idx) / DIM));
`else
    map_pos = idx;
`endif
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_loader_if
// Valid/ready element stream into the matrix loader.
//   in_valid  producer -> loader  in_data holds a valid element
//   in_data   producer -> loader  element value (row-major, element 0 first)
//   in_ready  loader -> producer  loader accepts an element this cycle
// Modports: master = element producer, slave = matrix loader.
// -----------------------------------------------------------------------------
interface matrix_loader_if;
  import matrix_pkg::*;

  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Assembles a DIM x DIM matrix of ELEM_W-bit elements from a valid/ready
// stream and issues a single-cycle load to the downstream matrix storage
// register once the last element has arrived.
// Ports:
//   CLK           clock, rising edge
//   reset         synchronous, active-high reset
//   start         begin a new fill (honoured only in IDLE)
//   abort         abandon the current fill (FILL only); no load issued
//   s_if          element stream (slave side: in_valid, in_data, in_ready)
//   Min           assembled matrix, to the memory Min input
//   memory_state  MEM_LATCH / MEM_LOAD, to the memory memory_state input
//   busy          high in FILL and COMMIT
//   done          one-cycle pulse after a commit
//   elem_idx      index of the next element to be accepted
// Optional build macro: MATRIX_LOADER_TRANSPOSE_EN (transposed storage,
// handled by matrix_pkg::map_pos; timing is identical in both builds).
// All outputs are registered.
// -----------------------------------------------------------------------------
module matrix_loader
  import matrix_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  matrix_loader_if.slave   s_if,
  output logic [MAT_W-1:0] Min,
  output logic             memory_state,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] elem_idx
);

  loader_state_t    r_state;
  logic [MAT_W-1:0] r_min;
  logic [IDX_W-1:0] r_elem_idx;
  logic             r_in_ready;
  logic             r_mem_state;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_pos;
  logic             w_xfer;

  assign w_pos  = map_pos(r_elem_idx);
  assign w_xfer = s_if.in_valid && r_in_ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_min       <= '0;
      r_elem_idx  <= '0;
      r_in_ready  <= 1'b0;
      r_mem_state <= MEM_LATCH;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_state <= MEM_LATCH;
          // Min is left untouched: each element slot is overwritten on arrival.
          if (start) begin
            r_state    <= FILL;
            r_elem_idx <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        FILL: begin
          // abort takes priority over a simultaneous transfer.
          if (abort) begin
            r_state    <= IDLE;
            r_elem_idx <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_min[ELEM_W*int'(w_pos) +: ELEM_W] <= s_if.in_data;
            if (r_elem_idx == IDX_W'(NUM_ELEM - 1)) begin
              r_state     <= COMMIT;
              r_elem_idx  <= '0;
              r_in_ready  <= 1'b0;
              r_mem_state <= MEM_LOAD;
            end else begin
              r_elem_idx <= r_elem_idx + 1'b1;
            end
          end
        end

        COMMIT: begin
          // Load is held exactly one cycle; abort and start are ignored here.
          r_state     <= IDLE;
          r_mem_state <= MEM_LATCH;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_mem_state <= MEM_LATCH;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.in_ready = r_in_ready;
  assign Min           = r_min;
  assign memory_state  = r_mem_state;
  assign busy          = r_busy;
  assign done          = r_done;
  assign elem_idx      = r_elem_idx;

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for the 256-bit matrix storage register.
- Accepts matrix elements one at a time over a valid/ready stream and assembles them into a 4x4 matrix of 16-bit elements.
- When all elements have arrived, raises memory_state = load for exactly one cycle so the storage register captures Min.
- Sits between the host/command interface and the matrix memory; drives that memory's Min and memory_state inputs directly.

Parameters:
- ELEM_W, 16, bit width of one matrix element.
- DIM, 4, matrix dimension (DIM x DIM elements).
- MAT_W, ELEM_W*DIM*DIM (256), assembled matrix width; derived, not overridden.

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new matrix fill; honoured only in IDLE.
- abort  input  1  abandon the current fill; no load issued.
- in_valid  input  1  in_data holds a valid element.
- in_data  input  ELEM_W  element value, row-major order, element 0 first.
- in_ready  output  1  loader accepts an element this cycle.
- Min  output  MAT_W  assembled matrix, to the memory Min input.
- memory_state  output  1  0 = latch, 1 = load; to the memory memory_state input.
- busy  output  1  high in FILL and COMMIT.
- done  output  1  one-cycle pulse after a commit.
- elem_idx  output  log2(DIM*DIM)  index of the next element to be accepted.

Behaviour:
- Reset values:
  - Outputs: in_ready=0, Min=0, memory_state=0 (latch), busy=0, done=0, elem_idx=0.
  - State: IDLE.
- All outputs are registered.
- FSM states: IDLE, FILL, COMMIT.
- IDLE:
  - start=1 -> FILL; elem_idx<=0.
  - in_ready rises the cycle after the start edge.
  - Min keeps its previous contents; elements are overwritten as they arrive.
- FILL:
  - in_ready=1 while in this state.
  - Transfer occurs on an edge where in_valid && in_ready.
  - On transfer: Min[ELEM_W*p +: ELEM_W] <= in_data, where p = elem_idx mapped per the Optional Feature (identity by default, element 0 at LSBs); elem_idx increments.
  - in_valid=0 -> hold; no timeout.
- Last element (elem_idx = DIM*DIM-1 transferred):
  - -> COMMIT; in_ready drops the next cycle; elem_idx wraps to 0.
- COMMIT:
  - memory_state=1 for exactly one cycle; Min stable and complete during that cycle.
  - -> IDLE next edge with memory_state=0 and done=1 for one cycle.
  - Net latency: last-element accept edge -> load cycle +1 -> done +2.
- start outside IDLE: ignored.
- start in the same cycle done is high: accepted; a back-to-back fill is legal.
- abort in FILL:
  - -> IDLE next edge; elem_idx<=0; no load issued; no done.
  - A transfer in the same cycle as abort is discarded (abort wins).
- abort in COMMIT or IDLE: ignored; a commit always completes.
- reset mid-FILL or mid-COMMIT: all outputs return to reset values on that edge; no load is issued.
- memory_state is never 1 for more than one consecutive cycle.

Optional Feature:
- Macro: MATRIX_LOADER_TRANSPOSE_EN.
- Defined:
  - Incoming row-major element i is written to position p = (i mod DIM)*DIM + (i div DIM).
  - The stored matrix is therefore the transpose of the stream.
- Undefined:
  - p = i (row-major storage).
- Handshake, timing and elem_idx behaviour are identical in both builds.

Decomposition:
- Package matrix_pkg holds:
  - ELEM_W, DIM, MAT_W.
  - MEM_LATCH=1'b0, MEM_LOAD=1'b1.
  - Loader state enum {IDLE, FILL, COMMIT}.
  - Position-mapping function (identity or transpose under the macro).
- No sub-module: the datapath is a single indexed register write.

Test Plan:
- Basic fill:
  - Stimulus: reset; start; stream 16'h0000..16'h000F with in_valid held high.
  - Required: Min = {16'h000F,...,16'h0000}; memory_state=1 for exactly one cycle, 1 cycle after the 16th accept; done 1 cycle later.
- Bubbles:
  - Stimulus: in_valid toggled 1/0 every cycle while streaming.
  - Required: same final Min; elem_idx advances only on transfers; load issued once.
- Abort:
  - Stimulus: abort after 7 elements.
  - Required: state IDLE, elem_idx=0, memory_state never 1; a following full fill of 16'hA000+i yields the correct Min.
- Reset mid-fill:
  - Stimulus: reset after 10 elements.
  - Required: Min=0, in_ready=0, no load; start is still honoured afterwards.
- Protocol edges:
  - Stimulus: start pulsed during FILL and during COMMIT; start asserted in the done cycle.
  - Required: starts during FILL/COMMIT are ignored; the done-cycle start begins a new fill with in_ready the next cycle.
- Transpose build:
  - Stimulus: build with MATRIX_LOADER_TRANSPOSE_EN; stream i = 0..15.
  - Required: element at position 1 = 4, position 4 = 1, position 15 = 15.
